// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared opcodes, widths and EX-stage state type
package pipeline_pkg;
    localparam int DATA_W = 16;
    localparam int OPC_W  = 4;
    localparam int REG_W  = 4;
    localparam int MEM_W  = 4;
    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    typedef enum logic {IDLE, MUL_BUSY} ex_state_e;
endpackage

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative shift-add multiply stepped by an external iteration count
module shift_add_multiplier #(
    parameter int WIDTH = 16,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [CW-1:0]      count,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q;

    // product includes the current iteration so the final step can be consumed directly
    always_comb begin
        product = acc_q + (b_q[count] ? ({{WIDTH{1'b0}}, a_q} << count) : '0);
        done    = busy && count == CW'(WIDTH - 1);
    end

    // latch operands on start, accumulate one partial product per busy cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            a_q   <= a;
            b_q   <= b;
            acc_q <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc_q <= product;
            busy  <= !done;
        end
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: EX pipeline stage with single-cycle ALU and stalling shift-add multiply
module execute_stage
    import pipeline_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W,
    parameter int OPCODE_WIDTH   = OPC_W,
    parameter int REG_ADDR_WIDTH = REG_W,
    parameter int MEM_ADDR_WIDTH = MEM_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      valid_in,
    input  logic [OPCODE_WIDTH-1:0]   opcode_in,
    input  logic [DATA_WIDTH-1:0]     operand1_in,
    input  logic [DATA_WIDTH-1:0]     operand2_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_addr_in,
    input  logic                      write_enable_in,
    input  logic                      store_enable_in,
    input  logic                      load_enable_in,
    input  logic [MEM_ADDR_WIDTH-1:0] mem_addr_in,
    output logic                      stall_out,
    output logic                      valid_out,
    output logic [DATA_WIDTH-1:0]     result_out,
    output logic [DATA_WIDTH-1:0]     store_data_out,
    output logic [REG_ADDR_WIDTH-1:0] reg_addr_out,
    output logic                      write_enable_out,
    output logic                      store_enable_out,
    output logic                      load_enable_out,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_out,
    output logic                      zero_flag,
    output logic                      carry_flag
);
    localparam int CW = $clog2(DATA_WIDTH);

    ex_state_e                 state_q, state_d;
    logic [CW-1:0]             count_q, count_d;
    logic                      is_mul, start, take, mul_busy, mul_done;
    logic [2*DATA_WIDTH-1:0]   mul_product, shl_wide;
    logic [DATA_WIDTH:0]       sum, diff;
    logic [DATA_WIDTH-1:0]     alu_res;
    logic                      alu_carry, alu_flags;
    logic [REG_ADDR_WIDTH-1:0] lat_reg_addr_q;
    logic [MEM_ADDR_WIDTH-1:0] lat_mem_addr_q;
    logic [DATA_WIDTH-1:0]     lat_store_data_q;
    logic                      lat_we_q, lat_se_q, lat_le_q;

    shift_add_multiplier #(.WIDTH(DATA_WIDTH), .CW(CW)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .count   (count_q),
        .a       (operand1_in),
        .b       (operand2_in),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // single-cycle ALU: result, carry and whether this opcode updates the flags
    always_comb begin
        sum       = {1'b0, operand1_in} + {1'b0, operand2_in};
        diff      = {1'b0, operand1_in} - {1'b0, operand2_in};
        shl_wide  = {{DATA_WIDTH{1'b0}}, operand1_in} << operand2_in[CW-1:0];
        alu_res   = operand1_in;
        alu_carry = 1'b0;
        alu_flags = 1'b0;
        case (opcode_in)
            OP_ADD: begin alu_res = sum[DATA_WIDTH-1:0]; alu_carry = sum[DATA_WIDTH]; alu_flags = 1'b1; end
            OP_SUB: begin alu_res = diff[DATA_WIDTH-1:0]; alu_carry = diff[DATA_WIDTH]; alu_flags = 1'b1; end
            OP_AND: begin alu_res = operand1_in & operand2_in; alu_flags = 1'b1; end
            OP_OR:  begin alu_res = operand1_in | operand2_in; alu_flags = 1'b1; end
            OP_XOR: begin alu_res = operand1_in ^ operand2_in; alu_flags = 1'b1; end
            OP_SHL: begin alu_res = shl_wide[DATA_WIDTH-1:0]; alu_carry = shl_wide[DATA_WIDTH]; alu_flags = 1'b1; end
            OP_SHR: begin alu_res = operand1_in >> operand2_in[CW-1:0]; alu_flags = 1'b1; end
            default: ;
        endcase
    end

    // next state, iteration counter and upstream stall; stall drops in the last busy cycle
    always_comb begin
        is_mul    = valid_in && opcode_in == OP_MUL;
        start     = state_q == IDLE && is_mul;
        take      = state_q == IDLE && valid_in && !is_mul;
        state_d   = start ? MUL_BUSY : (state_q == MUL_BUSY && mul_done) ? IDLE : state_q;
        count_d   = (mul_busy && !mul_done) ? count_q + CW'(1) : '0;
        stall_out = reset && (start || (state_q == MUL_BUSY && !mul_done));
    end

    // FSM state and iteration counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // EX/MEM bundle: ALU ops register immediately, MUL registers its latched bundle on completion
    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_out        <= 1'b0;
            result_out       <= '0;
            store_data_out   <= '0;
            reg_addr_out     <= '0;
            write_enable_out <= 1'b0;
            store_enable_out <= 1'b0;
            load_enable_out  <= 1'b0;
            mem_addr_out     <= '0;
            zero_flag        <= 1'b0;
            carry_flag       <= 1'b0;
            lat_reg_addr_q   <= '0;
            lat_mem_addr_q   <= '0;
            lat_store_data_q <= '0;
            lat_we_q         <= 1'b0;
            lat_se_q         <= 1'b0;
            lat_le_q         <= 1'b0;
        end else if (state_q == MUL_BUSY) begin
            valid_out        <= mul_done;
            write_enable_out <= mul_done && lat_we_q;
            store_enable_out <= mul_done && lat_se_q;
            load_enable_out  <= mul_done && lat_le_q;
            if (mul_done) begin
                result_out     <= mul_product[DATA_WIDTH-1:0];
                zero_flag      <= mul_product[DATA_WIDTH-1:0] == '0;
                carry_flag     <= |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
                reg_addr_out   <= lat_reg_addr_q;
                mem_addr_out   <= lat_mem_addr_q;
                store_data_out <= lat_store_data_q;
            end
        end else begin
            valid_out        <= take;
            write_enable_out <= take && write_enable_in;
            store_enable_out <= take && store_enable_in;
            load_enable_out  <= take && load_enable_in;
            if (take) begin
                result_out     <= alu_res;
                reg_addr_out   <= reg_addr_in;
                mem_addr_out   <= mem_addr_in;
                store_data_out <= operand2_in;
                if (alu_flags) begin
                    zero_flag  <= alu_res == '0;
                    carry_flag <= alu_carry;
                end
            end
            if (start) begin
                lat_reg_addr_q   <= reg_addr_in;
                lat_mem_addr_q   <= mem_addr_in;
                lat_store_data_q <= operand2_in;
                lat_we_q         <= write_enable_in;
                lat_se_q         <= store_enable_in;
                lat_le_q         <= load_enable_in;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors checked against a cycle-level behavioural model
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [3:0]  opcode_in = '0, reg_addr_in = '0, mem_addr_in = '0;
    logic [15:0] operand1_in = '0, operand2_in = '0;
    logic        write_enable_in = 1'b0, store_enable_in = 1'b0, load_enable_in = 1'b0;
    logic        stall_out, valid_out, write_enable_out, store_enable_out, load_enable_out;
    logic        zero_flag, carry_flag;
    logic [15:0] result_out, store_data_out;
    logic [3:0]  reg_addr_out, mem_addr_out;

    int checks = 0;
    int errors = 0;
    int stall_cycles;

    execute_stage dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .opcode_in(opcode_in),
        .operand1_in(operand1_in), .operand2_in(operand2_in), .reg_addr_in(reg_addr_in),
        .write_enable_in(write_enable_in), .store_enable_in(store_enable_in),
        .load_enable_in(load_enable_in), .mem_addr_in(mem_addr_in), .stall_out(stall_out),
        .valid_out(valid_out), .result_out(result_out), .store_data_out(store_data_out),
        .reg_addr_out(reg_addr_out), .write_enable_out(write_enable_out),
        .store_enable_out(store_enable_out), .load_enable_out(load_enable_out),
        .mem_addr_out(mem_addr_out), .zero_flag(zero_flag), .carry_flag(carry_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // returns {flags_update, carry, result} from the opcode definitions
    function automatic logic [17:0] alu(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] w;
        logic [15:0] d;
        int sh;
        sh = int'(b[3:0]);
        case (op)
            4'd1: begin w = {16'b0, a} + {16'b0, b}; return {1'b1, w > 32'hFFFF, w[15:0]}; end
            4'd2: begin d = a - b; return {1'b1, a < b, d}; end
            4'd3: return {2'b10, a & b};
            4'd4: return {2'b10, a | b};
            4'd5: return {2'b10, a ^ b};
            4'd6: begin w = {16'b0, a} << sh; return {1'b1, sh == 0 ? 1'b0 : a[16 - sh], w[15:0]}; end
            4'd7: return {2'b10, a >> sh};
            4'd8: begin w = {16'b0, a} * {16'b0, b}; return {1'b1, w[31:16] != 16'h0, w[15:0]}; end
            default: return {2'b00, a};
        endcase
    endfunction

    int          wait_cnt = 0;
    logic        e_valid = 0, e_we = 0, e_se = 0, e_le = 0, e_zero = 0, e_carry = 0;
    logic [15:0] e_res = 0, e_sd = 0, p_res = 0, p_sd = 0;
    logic [3:0]  e_ra = 0, e_ma = 0, p_ra = 0, p_ma = 0;
    logic        p_we = 0, p_se = 0, p_le = 0, p_carry = 0;

    // model: a MUL holds the stage for 16 more edges, then its bundle appears
    always @(posedge clk) begin : model
        logic [17:0] r;
        r = alu(opcode_in, operand1_in, operand2_in);
        if (!reset) begin
            wait_cnt = 0;
            {e_valid, e_we, e_se, e_le, e_zero, e_carry} = '0;
            e_res = 0; e_sd = 0; e_ra = 0; e_ma = 0;
        end else if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                e_valid = 1; e_res = p_res; e_zero = (p_res == 0); e_carry = p_carry;
                e_ra = p_ra; e_ma = p_ma; e_sd = p_sd; e_we = p_we; e_se = p_se; e_le = p_le;
            end else begin
                {e_valid, e_we, e_se, e_le} = '0;
            end
        end else if (valid_in && opcode_in == 4'd8) begin
            wait_cnt = 16;
            p_res = r[15:0]; p_carry = r[16]; p_ra = reg_addr_in; p_ma = mem_addr_in; p_sd = operand2_in;
            p_we = write_enable_in; p_se = store_enable_in; p_le = load_enable_in;
            {e_valid, e_we, e_se, e_le} = '0;
        end else if (valid_in) begin
            e_valid = 1; e_res = r[15:0];
            if (r[17]) begin e_zero = (r[15:0] == 0); e_carry = r[16]; end
            e_ra = reg_addr_in; e_ma = mem_addr_in; e_sd = operand2_in;
            e_we = write_enable_in; e_se = store_enable_in; e_le = load_enable_in;
        end else begin
            {e_valid, e_we, e_se, e_le} = '0;
        end
    end

    // compare every cycle, mid-way between edges, once inputs have settled
    always @(negedge clk) begin
        #2;
        chk("stall", stall_out, reset && ((wait_cnt == 0 && valid_in && opcode_in == 4'd8) || wait_cnt > 1));
        chk("valid", valid_out, e_valid);
        chk("we", write_enable_out, e_we);
        chk("se", store_enable_out, e_se);
        chk("le", load_enable_out, e_le);
        chk("result", result_out, e_res);
        chk("zero", zero_flag, e_zero);
        chk("carry", carry_flag, e_carry);
        if (e_valid) begin
            chk("reg_addr", reg_addr_out, e_ra);
            chk("mem_addr", mem_addr_out, e_ma);
            chk("store_data", store_data_out, e_sd);
        end
    end

    task automatic drive(input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] ra, input logic w, input logic s, input logic l, input logic [3:0] ma);
        @(negedge clk);
        valid_in = v; opcode_in = op; operand1_in = a; operand2_in = b; reg_addr_in = ra;
        write_enable_in = w; store_enable_in = s; load_enable_in = l; mem_addr_in = ma;
    endtask

    task automatic idle();
        drive(0, 4'd0, 16'h0, 16'h0, 4'h0, 0, 0, 0, 4'h0);
    endtask

    // counts stall cycles from presentation, returning at the final busy cycle
    task automatic wait_mul();
        stall_cycles = 0;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!stall_out) break;
            stall_cycles++;
            @(negedge clk);
            #1;
        end
        chk("mul_stall_cycles", stall_cycles, 16);
    endtask

    initial begin
        valid_in = 1; opcode_in = 4'd1; operand1_in = 16'h0001; operand2_in = 16'h0001;
        reg_addr_in = 4'h5; write_enable_in = 1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", valid_out, 0);
        chk("rst_result", result_out, 16'h0000);
        chk("rst_we", write_enable_out, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_reg_addr", reg_addr_out, 4'h0);
        reset = 1; valid_in = 0;

        drive(1, 4'd1, 16'hFFFF, 16'h0001, 4'h3, 1, 0, 0, 4'h0);
        drive(1, 4'd2, 16'h0003, 16'h0005, 4'h4, 1, 0, 0, 4'h0);
        #1;
        chk("add_result", result_out, 16'h0000);
        chk("add_zero", zero_flag, 1);
        chk("add_carry", carry_flag, 1);
        chk("add_valid", valid_out, 1);
        drive(1, 4'd3, 16'hF0F0, 16'h3C3C, 4'h1, 1, 0, 0, 4'h0);
        #1;
        chk("sub_result", result_out, 16'hFFFE);
        chk("sub_carry", carry_flag, 1);
        drive(1, 4'd4, 16'h1200, 16'h0034, 4'h1, 1, 0, 0, 4'h0);
        #1 chk("and_result", result_out, 16'h3030);
        drive(1, 4'd5, 16'hAAAA, 16'hAAAA, 4'h1, 1, 0, 0, 4'h0);
        #1 chk("or_result", result_out, 16'h1234);
        drive(1, 4'd6, 16'h8001, 16'h0001, 4'h1, 1, 0, 0, 4'h0);
        #1 chk("xor_zero", zero_flag, 1);
        drive(1, 4'd6, 16'h1234, 16'h0000, 4'h1, 1, 0, 0, 4'h0);
        #1;
        chk("shl_result", result_out, 16'h0002);
        chk("shl_carry", carry_flag, 1);
        drive(1, 4'd7, 16'h8000, 16'h000F, 4'h1, 1, 0, 0, 4'h0);
        #1 chk("shl0_carry", carry_flag, 0);
        idle();
        #1 chk("shr_result", result_out, 16'h0001);

        drive(1, 4'd8, 16'h00AA, 16'h0055, 4'hA, 1, 0, 0, 4'h0);
        wait_mul();
        drive(1, 4'd1, 16'h0001, 16'h0001, 4'h2, 1, 0, 0, 4'h0);
        #1;
        chk("mul_result", result_out, 16'h3872);
        chk("mul_carry", carry_flag, 0);
        chk("mul_reg_addr", reg_addr_out, 4'hA);
        chk("mul_we", write_enable_out, 1);
        drive(1, 4'd8, 16'h0100, 16'h0100, 4'h7, 1, 0, 0, 4'h0);
        #1;
        chk("post_mul_add", result_out, 16'h0002);
        chk("post_mul_valid", valid_out, 1);
        wait_mul();
        idle();
        #1;
        chk("mul_ovf_result", result_out, 16'h0000);
        chk("mul_ovf_zero", zero_flag, 1);
        chk("mul_ovf_carry", carry_flag, 1);

        drive(1, 4'd8, 16'h0003, 16'h0005, 4'h9, 1, 0, 0, 4'h0);
        repeat (9) @(negedge clk);
        reset = 0; valid_in = 0;
        @(negedge clk);
        #1;
        chk("abort_stall", stall_out, 0);
        chk("abort_valid", valid_out, 0);
        reset = 1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            #1 chk("abort_no_result", valid_out, 0);
        end

        drive(1, 4'd1, 16'hFFFF, 16'h0001, 4'h3, 1, 0, 0, 4'h0);
        drive(1, 4'hD, 16'h00FF, 16'h1111, 4'h0, 0, 0, 1, 4'h6);
        idle();
        #1;
        chk("load_result", result_out, 16'h00FF);
        chk("load_le", load_enable_out, 1);
        chk("load_mem_addr", mem_addr_out, 4'h6);
        chk("load_zero_held", zero_flag, 1);
        chk("load_carry_held", carry_flag, 1);
        idle();
        repeat (2) @(negedge clk);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
